imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL provide parameter ADDR_W, default 10, instruction-memory word-address width; MAX_WORDS = 2**ADDR_W.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-005 SHALL have port in_valid  input  1  byte-stream valid.
REQ-006 SHALL have port in_data  input  8  byte-stream data.
REQ-007 SHALL have port in_ready  output  1  loader can accept a byte.
REQ-008 SHALL have port imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 SHALL have port imem_addr  output  ADDR_W  word address of the write.
REQ-010 SHALL have port imem_wdata  output  32  instruction word written.
REQ-011 SHALL have port core_rst_n  output  1  active-low reset for the Processing Element.
REQ-012 SHALL have ports busy, done, error  output  1 each, and err_code  output  2 (1 = zero length, 2 = oversize, 3 = checksum).

Function
REQ-013 SHALL implement states IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
REQ-014 Byte transfer SHALL occur only on a cycle with in_valid=1 and in_ready=1; in_ready=1 exactly in LEN0, LEN1, DATA, CSUM.
REQ-015 start in IDLE, DONE or ERR SHALL move to LEN0 next cycle and clear done, error, err_code, word counter, byte counter and checksum; core_rst_n SHALL be 0 from that cycle on.
REQ-016 start in LEN0, LEN1, DATA or CSUM SHALL be ignored.
REQ-017 busy SHALL be 1 exactly in LEN0, LEN1, DATA, CSUM.
REQ-018 Stream format SHALL be: length low byte, length high byte (word count), 4*length data bytes, one checksum byte.
REQ-019 On the LEN1 byte: length 0 SHALL go to ERR with err_code 1; length > MAX_WORDS SHALL go to ERR with err_code 2; otherwise DATA.
REQ-020 Data bytes SHALL be assembled little-endian (first byte -> bits 7:0).
REQ-021 The cycle after the 4th byte of a word is accepted, imem_we SHALL be 1 for exactly one cycle with imem_addr = word index (0-based) and imem_wdata = assembled word.
REQ-022 After the last word's 4th byte the state SHALL move to CSUM; further bytes SHALL not produce writes.
REQ-023 Checksum SHALL be the XOR of both length bytes and all data bytes; a matching CSUM byte SHALL go to DONE, a mismatch SHALL go to ERR with err_code 3.
REQ-024 DONE SHALL drive done=1 and core_rst_n=1; ERR SHALL drive error=1 and core_rst_n=0; both hold until start or reset.
REQ-025 in_valid gaps of any length SHALL be tolerated with no timeout and no state change.
REQ-026 Words written before an error SHALL remain written; no rollback.

Reset
REQ-027 rst=0 SHALL immediately force state IDLE and in_ready, imem_we, imem_addr, imem_wdata, busy, done, error, err_code, core_rst_n all to 0, including mid-load.
REQ-028 After rst returns to 1 the loader SHALL remain in IDLE with core_rst_n=0 until start.

Verification
REQ-029 start; bytes 02 00 13 00 50 00 93 00 A0 00 72 -> writes addr0=0x00500013, addr1=0x00A00093, done=1, core_rst_n=1, error=0.
REQ-030 Same stream with checksum 73 -> both words written, error=1, err_code=3, core_rst_n=0, done=0.
REQ-031 start; bytes 00 00 -> ERR after second byte, err_code=1, no imem_we pulse.
REQ-032 ADDR_W=2; length 05 00 -> ERR, err_code=2, in_ready=0 next cycle.
REQ-033 rst=0 during DATA after 6 bytes -> all outputs 0 at once; release rst, start, valid 1-word stream -> correct write to addr0, done=1.
REQ-034 in_valid toggled 1-of-3 cycles plus start pulses while busy -> results identical to REQ-029.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus used by imem_loader.
//   in_valid/in_data/in_ready : byte stream into the loader (valid/ready handshake)
//   imem_we/imem_addr/imem_wdata : one-word write port toward the instruction memory
// master = host side (drives the stream, observes writes); slave = loader side.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed, checksummed byte stream,
// assembles little-endian 32-bit words, writes them to instruction memory and
// releases the processing element reset only after a fully verified load.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   start            : single-cycle load request (honoured in IDLE/DONE/ERR)
//   bus (slave)      : byte stream in + instruction-memory write out
//   core_rst_n       : active-low PE reset, high only in DONE
//   busy/done/error  : load status; err_code 1=zero length, 2=oversize, 3=checksum
module imem_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  imem_loader_if.slave bus,
  output logic       core_rst_n,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;
  localparam int unsigned CNT_W     = ADDR_W + 1;

  localparam logic [1:0] EC_NONE = 2'd0;
  localparam logic [1:0] EC_ZERO = 2'd1;
  localparam logic [1:0] EC_SIZE = 2'd2;
  localparam logic [1:0] EC_CSUM = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  word_cnt, word_cnt_n;
  logic [1:0]        byte_cnt, byte_cnt_n;
  logic [7:0]        csum, csum_n;
  logic [7:0]        len_lo, len_lo_n;
  logic [15:0]       length, length_n;
  logic [23:0]       asm_q, asm_n;
  logic [1:0]        err_code_n;
  logic              we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0]       wdata_n;
  logic              ready_n;
  logic              busy_n;
  logic              accept_c;
  logic [15:0]       len_full_c;
  logic              last_word_c;

  assign accept_c    = bus.in_valid & bus.in_ready;
  assign len_full_c  = {bus.in_data, len_lo};
  assign last_word_c = (32'(word_cnt) + 32'd1) == 32'(length);

  // Next-state and next-value logic
  always_comb begin
    state_n    = state;
    word_cnt_n = word_cnt;
    byte_cnt_n = byte_cnt;
    csum_n     = csum;
    len_lo_n   = len_lo;
    length_n   = length;
    asm_n      = asm_q;
    err_code_n = err_code;
    we_n       = 1'b0;
    addr_n     = bus.imem_addr;
    wdata_n    = bus.imem_wdata;

    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_n    = ST_LEN0;
          word_cnt_n = '0;
          byte_cnt_n = '0;
          csum_n     = '0;
          err_code_n = EC_NONE;
        end
      end
      ST_LEN0: begin
        if (accept_c) begin
          len_lo_n = bus.in_data;
          csum_n   = csum ^ bus.in_data;
          state_n  = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (accept_c) begin
          csum_n   = csum ^ bus.in_data;
          length_n = len_full_c;
          if (len_full_c == 16'd0) begin
            state_n    = ST_ERR;
            err_code_n = EC_ZERO;
          end else if (32'(len_full_c) > MAX_WORDS) begin
            state_n    = ST_ERR;
            err_code_n = EC_SIZE;
          end else begin
            state_n = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept_c) begin
          csum_n     = csum ^ bus.in_data;
          byte_cnt_n = byte_cnt + 2'd1;
          case (byte_cnt)
            2'd0: asm_n[7:0]   = bus.in_data;
            2'd1: asm_n[15:8]  = bus.in_data;
            2'd2: asm_n[23:16] = bus.in_data;
            default: begin
              // Fourth byte completes the word: write it next cycle
              we_n       = 1'b1;
              addr_n     = word_cnt[ADDR_W-1:0];
              wdata_n    = {bus.in_data, asm_q};
              word_cnt_n = word_cnt + CNT_W'(1);
              if (last_word_c) state_n = ST_CSUM;
            end
          endcase
        end
      end
      ST_CSUM: begin
        if (accept_c) begin
          if (bus.in_data == csum) begin
            state_n = ST_DONE;
          end else begin
            state_n    = ST_ERR;
            err_code_n = EC_CSUM;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    ready_n = (state_n == ST_LEN0) || (state_n == ST_LEN1) ||
              (state_n == ST_DATA) || (state_n == ST_CSUM);
    busy_n  = ready_n;
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      word_cnt       <= '0;
      byte_cnt       <= '0;
      csum           <= '0;
      len_lo         <= '0;
      length         <= '0;
      asm_q          <= '0;
      err_code       <= EC_NONE;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      core_rst_n     <= 1'b0;
    end else begin
      state          <= state_n;
      word_cnt       <= word_cnt_n;
      byte_cnt       <= byte_cnt_n;
      csum           <= csum_n;
      len_lo         <= len_lo_n;
      length         <= length_n;
      asm_q          <= asm_n;
      err_code       <= err_code_n;
      bus.in_ready   <= ready_n;
      bus.imem_we    <= we_n;
      bus.imem_addr  <= addr_n;
      bus.imem_wdata <= wdata_n;
      busy           <= busy_n;
      done           <= (state_n == ST_DONE);
      error          <= (state_n == ST_ERR);
      core_rst_n     <= (state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: one default instance (ADDR_W=10)
// and one small instance (ADDR_W=2) for the oversize boundary.
module tb_imem_loader;

  logic       clk;
  logic       rst;
  logic       start, start2;
  logic       core_rst_n, busy, done, error;
  logic [1:0] err_code;
  logic       core_rst_n2, busy2, done2, error2;
  logic [1:0] err_code2;

  int tests;
  int fails;

  logic [9:0]  wa[$];
  logic [31:0] wd[$];
  logic [1:0]  wa2[$];
  logic [31:0] wd2[$];

  imem_loader_if #(.ADDR_W(10)) bus ();
  imem_loader_if #(.ADDR_W(2))  bus2 ();

  imem_loader #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .core_rst_n(core_rst_n), .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  imem_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bus(bus2),
    .core_rst_n(core_rst_n2), .busy(busy2), .done(done2), .error(error2), .err_code(err_code2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitors: one entry per cycle with the strobe high
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wa.push_back(bus.imem_addr);
      wd.push_back(bus.imem_wdata);
    end
    if (bus2.imem_we === 1'b1) begin
      wa2.push_back(bus2.imem_addr);
      wd2.push_back(bus2.imem_wdata);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Offer one byte at a negedge once in_ready is high; returns at the next negedge
  task automatic send_byte(input int sel, input logic [7:0] b);
    int n = 0;
    while (((sel == 0) ? bus.in_ready : bus2.in_ready) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 20) begin
      fails++;
      $display("FAIL send_byte: in_ready got 0 want 1 for byte %02h on dut%0d", b, sel);
    end
    if (sel == 0) begin bus.in_valid = 1'b1; bus.in_data = b; end
    else          begin bus2.in_valid = 1'b1; bus2.in_data = b; end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus2.in_valid = 1'b0;
  endtask

  task automatic pulse_start(input int sel);
    if (sel == 0) start = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; start2 = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00;
    bus2.in_valid = 1'b0; bus2.in_data = 8'h00;
    idle(3);
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    tests++; if (bus.imem_we !== 1'b0) begin fails++; $display("FAIL reset_imem_we: got %b want 0", bus.imem_we); end
    tests++; if (bus.imem_addr !== 10'd0 || bus.imem_wdata !== 32'd0) begin fails++; $display("FAIL reset_addr_data: got %h/%h want 0/0", bus.imem_addr, bus.imem_wdata); end
    tests++; if ({busy, done, error, err_code, core_rst_n} !== 6'b0) begin fails++; $display("FAIL reset_status: got %b want 000000", {busy, done, error, err_code, core_rst_n}); end
    rst = 1'b1;
    idle(4);
    tests++; if (core_rst_n !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL post_reset_idle: core_rst_n/busy got %b%b want 00", core_rst_n, busy); end
  endtask

  task automatic test_good_load;
    logic [7:0] s [11] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h72};
    wa.delete(); wd.delete();
    pulse_start(0);
    tests++; if ({busy, bus.in_ready, core_rst_n} !== 3'b110) begin fails++; $display("FAIL good_start: busy/ready/core_rst_n got %b want 110", {busy, bus.in_ready, core_rst_n}); end
    for (int i = 0; i < 6; i++) send_byte(0, s[i]);
    tests++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 10'd0 || bus.imem_wdata !== 32'h00500013) begin fails++; $display("FAIL good_first_write: got we=%b addr=%h data=%h want 1/000/00500013", bus.imem_we, bus.imem_addr, bus.imem_wdata); end
    for (int i = 6; i < 11; i++) send_byte(0, s[i]);
    idle(2);
    tests++; if ({done, core_rst_n, error, busy, bus.in_ready} !== 5'b11000) begin fails++; $display("FAIL good_status: done/core/err/busy/ready got %b want 11000", {done, core_rst_n, error, busy, bus.in_ready}); end
    tests++; if (wa.size() != 2) begin fails++; $display("FAIL good_write_count: got %0d want 2", wa.size()); end
    else if (wa[0] !== 10'd0 || wd[0] !== 32'h00500013 || wa[1] !== 10'd1 || wd[1] !== 32'h00A00093) begin
      fails++; $display("FAIL good_writes: got %h=%h %h=%h want 000=00500013 001=00a00093", wa[0], wd[0], wa[1], wd[1]);
    end
  endtask

  task automatic test_bad_csum;
    logic [7:0] s [11] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h73};
    wa.delete(); wd.delete();
    pulse_start(0);
    tests++; if ({done, core_rst_n, busy} !== 3'b001) begin fails++; $display("FAIL restart_from_done: done/core/busy got %b want 001", {done, core_rst_n, busy}); end
    for (int i = 0; i < 11; i++) send_byte(0, s[i]);
    idle(2);
    tests++; if ({error, err_code, core_rst_n, done} !== 5'b11100) begin fails++; $display("FAIL csum_status: err/code/core/done got %b want 11100", {error, err_code, core_rst_n, done}); end
    tests++; if (wa.size() != 2) begin fails++; $display("FAIL csum_write_count: got %0d want 2", wa.size()); end
    else if (wd[0] !== 32'h00500013 || wd[1] !== 32'h00A00093) begin
      fails++; $display("FAIL csum_writes: got %h %h want 00500013 00a00093", wd[0], wd[1]);
    end
  endtask

  task automatic test_zero_len;
    wa.delete(); wd.delete();
    pulse_start(0);
    tests++; if ({error, err_code, busy} !== 4'b0001) begin fails++; $display("FAIL restart_from_err: err/code/busy got %b want 0001", {error, err_code, busy}); end
    send_byte(0, 8'h00);
    send_byte(0, 8'h00);
    tests++; if ({error, err_code, bus.in_ready, busy} !== 5'b10100) begin fails++; $display("FAIL zero_len_status: err/code/ready/busy got %b want 10100", {error, err_code, bus.in_ready, busy}); end
    idle(3);
    tests++; if (wa.size() != 0) begin fails++; $display("FAIL zero_len_writes: got %0d want 0", wa.size()); end
  endtask

  task automatic test_oversize;
    wa2.delete(); wd2.delete();
    pulse_start(1);
    send_byte(1, 8'h05);
    send_byte(1, 8'h00);
    tests++; if ({bus2.in_ready, error2, err_code2, busy2} !== 5'b01100) begin fails++; $display("FAIL oversize: ready/err/code/busy got %b want 01100", {bus2.in_ready, error2, err_code2, busy2}); end
    // Exactly MAX_WORDS (4) words must be accepted
    pulse_start(1);
    send_byte(1, 8'h04);
    send_byte(1, 8'h00);
    tests++; if ({busy2, bus2.in_ready, error2} !== 3'b110) begin fails++; $display("FAIL max_len_accept: busy/ready/err got %b want 110", {busy2, bus2.in_ready, error2}); end
    for (int i = 0; i < 16; i++) send_byte(1, 8'(i));
    send_byte(1, 8'h04);
    idle(2);
    tests++; if ({done2, error2} !== 2'b10) begin fails++; $display("FAIL max_len_done: done/err got %b want 10", {done2, error2}); end
    tests++; if (wa2.size() != 4) begin fails++; $display("FAIL max_len_count: got %0d want 4", wa2.size()); end
    else if (wa2[3] !== 2'd3 || wd2[3] !== 32'h0F0E0D0C || wd2[0] !== 32'h03020100) begin
      fails++; $display("FAIL max_len_writes: got w0=%h a3=%h w3=%h want 03020100 3 0f0e0d0c", wd2[0], wa2[3], wd2[3]);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] s [6] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00};
    logic [7:0] t [7] = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23};
    pulse_start(0);
    for (int i = 0; i < 6; i++) send_byte(0, s[i]);
    rst = 1'b0;
    #1;
    tests++; if ({bus.in_ready, bus.imem_we, busy, done, error, err_code, core_rst_n} !== 8'b0) begin fails++; $display("FAIL mid_reset_status: got %b want 00000000", {bus.in_ready, bus.imem_we, busy, done, error, err_code, core_rst_n}); end
    tests++; if (bus.imem_addr !== 10'd0 || bus.imem_wdata !== 32'd0) begin fails++; $display("FAIL mid_reset_bus: got %h/%h want 0/0", bus.imem_addr, bus.imem_wdata); end
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    wa.delete(); wd.delete();
    pulse_start(0);
    for (int i = 0; i < 7; i++) send_byte(0, t[i]);
    idle(2);
    tests++; if ({done, core_rst_n, error} !== 3'b110) begin fails++; $display("FAIL post_reset_load: done/core/err got %b want 110", {done, core_rst_n, error}); end
    tests++; if (wa.size() != 1) begin fails++; $display("FAIL post_reset_count: got %0d want 1", wa.size()); end
    else if (wa[0] !== 10'd0 || wd[0] !== 32'hDEADBEEF) begin
      fails++; $display("FAIL post_reset_write: got %h=%h want 000=deadbeef", wa[0], wd[0]);
    end
  endtask

  task automatic test_gaps;
    logic [7:0] s [11] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h72};
    wa.delete(); wd.delete();
    pulse_start(0);
    for (int i = 0; i < 11; i++) begin
      idle(1);
      pulse_start(0);
      send_byte(0, s[i]);
    end
    idle(2);
    tests++; if ({done, core_rst_n, error, err_code} !== 5'b11000) begin fails++; $display("FAIL gaps_status: done/core/err/code got %b want 11000", {done, core_rst_n, error, err_code}); end
    tests++; if (wa.size() != 2) begin fails++; $display("FAIL gaps_write_count: got %0d want 2", wa.size()); end
    else if (wa[0] !== 10'd0 || wd[0] !== 32'h00500013 || wa[1] !== 10'd1 || wd[1] !== 32'h00A00093) begin
      fails++; $display("FAIL gaps_writes: got %h=%h %h=%h want 000=00500013 001=00a00093", wa[0], wd[0], wa[1], wd[1]);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset;
    test_good_load;
    test_bad_csum;
    test_zero_len;
    test_oversize;
    test_reset_mid;
    test_gaps;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
